periph_sequencer: RTL and testbench
===================================

PERIPH_SEQUENCER -- requirements
Module: periph_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port iGo  input  1  start request from CPU status-register write; sampled only in IDLE.
REQ-004 SHALL have port iMode  input  2  00 capture-only, 01 accelerate-only, 10 capture-then-accelerate, 11 illegal; latched on accepted iGo.
REQ-005 SHALL have port iAbort  input  1  cancel current job.
REQ-006 SHALL have port iAck  input  1  CPU acknowledge; clears DONE/ERR.
REQ-007 SHALL have port iTimeout  input  16  per-phase cycle limit, latched on accepted iGo; 0 disables timeout.
REQ-008 SHALL have port iCCD_done  input  1  capture complete (level, sampled each cycle).
REQ-009 SHALL have port iACC_done  input  1  accelerator complete (level, sampled each cycle).
REQ-010 SHALL have port oCCD_en  output  1  capture enable.
REQ-011 SHALL have port oACC_en  output  1  accelerator enable.
REQ-012 SHALL have port oACC_start  output  1  one-cycle accelerator start pulse.
REQ-013 SHALL have port oBusy  output  1  high in any state except IDLE, DONE, ERR.
REQ-014 SHALL have port oDone  output  1  job completed; held until iAck.
REQ-015 SHALL have port oError  output  1  job failed; held until iAck.
REQ-016 SHALL have port oErrCode  output  2  00 none, 01 illegal mode, 10 CCD timeout, 11 ACC timeout.
REQ-017 SHALL have port oState  output  3  IDLE=0, CCD=1, ACC_START=2, ACC_WAIT=3, DONE=4, ERR=5.
REQ-018 SHALL have port oCycles  output  16  job duration in cycles, saturating.

Function
REQ-019 All outputs SHALL be registered; oCCD_en/oACC_en/oACC_start/oBusy/oDone/oError decoded from registered state only.
REQ-020 IDLE: iGo with mode 00/10 -> CCD; mode 01 -> ACC_START; mode 11 -> ERR with oErrCode=01; transition takes effect next edge.
REQ-021 CCD: oCCD_en=1; iCCD_done=1 -> DONE (mode 00) or ACC_START (mode 10).
REQ-022 ACC_START: oACC_en=1, oACC_start=1 for exactly one cycle; unconditionally -> ACC_WAIT.
REQ-023 ACC_WAIT: oACC_en=1; iACC_done=1 -> DONE.
REQ-024 DONE/ERR: iAck -> IDLE; iGo ignored; oErrCode cleared on leaving ERR.
REQ-025 Phase counter SHALL clear on entry to CCD and ACC_WAIT, increment each cycle in those states; when iTimeout!=0 and counter == iTimeout-1 without done -> ERR, code 10 (CCD) or 11 (ACC_WAIT).
REQ-026 done and timeout in same cycle: done wins.
REQ-027 iAbort in CCD/ACC_START/ACC_WAIT -> IDLE next edge, all enables low, no oDone/oError; abort beats done and timeout; iAbort ignored in IDLE/DONE/ERR.
REQ-028 iGo while not IDLE SHALL be ignored; iMode/iTimeout changes mid-job have no effect.
REQ-029 oCycles SHALL clear on accepted iGo, increment each cycle while oBusy, saturate at 16'hFFFF, hold in DONE/ERR/IDLE.
REQ-030 iCCD_done/iACC_done SHALL be ignored outside their own wait state.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, all 1-bit outputs 0, oErrCode=00, oState=0, oCycles=0, counters 0; valid mid-job, no start pulse emitted after release.

Verification
REQ-032 Mode 10, iTimeout=0, iCCD_done after 5 cycles in CCD, iACC_done after 3 cycles in ACC_WAIT -> states 0,1x5,2,3x3,4; one oACC_start pulse; oDone=1; oCycles=10.
REQ-033 Mode 00, iTimeout=4, iCCD_done never -> ERR after 4 cycles in CCD, oErrCode=10, oCCD_en low; iAck -> IDLE, oErrCode=00.
REQ-034 Mode 01, iTimeout=3, iACC_done and timeout same cycle -> DONE, oError=0.
REQ-035 Mode 10, iAbort together with iCCD_done -> IDLE, no oACC_start, oDone=0; iGo during abort cycle ignored.
REQ-036 Mode 11 -> ERR, oErrCode=01, no enables asserted; rst_n pulse mid-ACC_WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/periph_sequencer.sv
// rtl/periph_sequencer.sv - capture/accelerate job sequencer with per-phase timeout and abort
module periph_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iGo,
    input  logic [1:0]  iMode,
    input  logic        iAbort,
    input  logic        iAck,
    input  logic [15:0] iTimeout,
    input  logic        iCCD_done,
    input  logic        iACC_done,
    output logic        oCCD_en,
    output logic        oACC_en,
    output logic        oACC_start,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [1:0]  oErrCode,
    output logic [2:0]  oState,
    output logic [15:0] oCycles
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CCD       = 3'd1,
        S_ACC_START = 3'd2,
        S_ACC_WAIT  = 3'd3,
        S_DONE      = 3'd4,
        S_ERR       = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MODE    = 2'b01;
    localparam logic [1:0] ERR_CCD_TMO = 2'b10;
    localparam logic [1:0] ERR_ACC_TMO = 2'b11;

    state_e      state_q, state_d;
    logic        then_acc_q, then_acc_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] phase_q, phase_d;
    logic [15:0] cycles_q, cycles_d;
    logic [1:0]  err_q, err_d;

    logic        ccd_en_q, acc_en_q, acc_start_q, busy_q, done_q, error_q;
    logic        in_job;
    logic        tmo_hit;

    assign in_job  = (state_q == S_CCD) || (state_q == S_ACC_START) || (state_q == S_ACC_WAIT);
    // Last permitted phase cycle; a done seen in the same cycle still takes priority.
    assign tmo_hit = (tmo_q != 16'd0) && (phase_q == tmo_q - 16'd1);

    always_comb begin
        state_d    = state_q;
        then_acc_d = then_acc_q;
        tmo_d      = tmo_q;
        phase_d    = phase_q;
        cycles_d   = cycles_q;
        err_d      = err_q;

        if (in_job && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (iGo) begin
                    then_acc_d = (iMode == 2'b10);
                    tmo_d      = iTimeout;
                    phase_d    = 16'd0;
                    err_d      = ERR_NONE;
                    // The accepting cycle counts as the first cycle of a legal job.
                    cycles_d   = 16'd1;
                    case (iMode)
                        2'b00, 2'b10: state_d = S_CCD;
                        2'b01:        state_d = S_ACC_START;
                        default: begin
                            state_d  = S_ERR;
                            err_d    = ERR_MODE;
                            cycles_d = 16'd0;
                        end
                    endcase
                end
            end
            S_CCD: begin
                if (iAbort) begin
                    state_d = S_IDLE;
                end else if (iCCD_done) begin
                    state_d = then_acc_q ? S_ACC_START : S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    err_d   = ERR_CCD_TMO;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_ACC_START: begin
                phase_d = 16'd0;
                state_d = iAbort ? S_IDLE : S_ACC_WAIT;
            end
            S_ACC_WAIT: begin
                if (iAbort) begin
                    state_d = S_IDLE;
                end else if (iACC_done) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                    err_d   = ERR_ACC_TMO;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_DONE: begin
                if (iAck) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (iAck) begin
                    state_d = S_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                err_d   = ERR_NONE;
            end
        endcase
    end

    // Output flags are registered from the next-state decode so they line up with oState.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            then_acc_q  <= 1'b0;
            tmo_q       <= 16'd0;
            phase_q     <= 16'd0;
            cycles_q    <= 16'd0;
            err_q       <= ERR_NONE;
            ccd_en_q    <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            then_acc_q  <= then_acc_d;
            tmo_q       <= tmo_d;
            phase_q     <= phase_d;
            cycles_q    <= cycles_d;
            err_q       <= err_d;
            ccd_en_q    <= (state_d == S_CCD);
            acc_en_q    <= (state_d == S_ACC_START) || (state_d == S_ACC_WAIT);
            acc_start_q <= (state_d == S_ACC_START);
            busy_q      <= (state_d == S_CCD) || (state_d == S_ACC_START) || (state_d == S_ACC_WAIT);
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERR);
        end
    end

    assign oCCD_en    = ccd_en_q;
    assign oACC_en    = acc_en_q;
    assign oACC_start = acc_start_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oError     = error_q;
    assign oErrCode   = err_q;
    assign oState     = state_q;
    assign oCycles    = cycles_q;

endmodule

// File: tb/tb_periph_sequencer.sv
// tb/tb_periph_sequencer.sv - randomized and directed bench for periph_sequencer
module tb_periph_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iGo = 1'b0;
    logic [1:0]  iMode = 2'b00;
    logic        iAbort = 1'b0;
    logic        iAck = 1'b0;
    logic [15:0] iTimeout = 16'd0;
    logic        iCCD_done = 1'b0;
    logic        iACC_done = 1'b0;
    logic        oCCD_en, oACC_en, oACC_start, oBusy, oDone, oError;
    logic [1:0]  oErrCode;
    logic [2:0]  oState;
    logic [15:0] oCycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    periph_sequencer dut (
        .clk(clk), .rst_n(rst_n), .iGo(iGo), .iMode(iMode), .iAbort(iAbort), .iAck(iAck),
        .iTimeout(iTimeout), .iCCD_done(iCCD_done), .iACC_done(iACC_done),
        .oCCD_en(oCCD_en), .oACC_en(oACC_en), .oACC_start(oACC_start), .oBusy(oBusy),
        .oDone(oDone), .oError(oError), .oErrCode(oErrCode), .oState(oState), .oCycles(oCycles)
    );

    // {ccd_en, acc_en, acc_start, busy} implied by a state number
    function automatic logic [3:0] flags_of(input int s);
        return {s == 1, (s == 2) || (s == 3), s == 2, (s >= 1) && (s <= 3)};
    endfunction

    task automatic idle_inputs();
        iGo = 1'b0; iAbort = 1'b0; iAck = 1'b0; iCCD_done = 1'b0; iACC_done = 1'b0;
    endtask

    // Plans a whole job from its parameters, plays it, and checks every cycle.
    // d1/d2: 1-based cycle within CCD/ACC_WAIT at which the done input arrives.
    task automatic run_job(input int m, input int t, input int d1, input int d2, input string name);
        int  exp_st[$];
        bit  cd[$];
        bit  ad[$];
        int  code, starts, cyc_exp, len, fin;
        bit  to, reach_acc;
        logic [15:0] held;
        code = 0;
        reach_acc = 0;
        cd.push_back(1'($urandom_range(0, 1)));
        ad.push_back(1'($urandom_range(0, 1)));
        if (m == 3) begin
            exp_st.push_back(5);
            code = 1;
        end else begin
            exp_st.push_back(m == 1 ? 2 : 1);
            reach_acc = (m == 1);
            if (m != 1) begin
                to  = (t != 0) && (t < d1);
                len = to ? t : d1;
                for (int j = 0; j < len; j++) begin
                    cd.push_back(j == d1 - 1);
                    ad.push_back(1'($urandom_range(0, 1)));
                    exp_st.push_back(j < len - 1 ? 1 : (to ? 5 : (m == 0 ? 4 : 2)));
                end
                if (to) code = 2;
                else if (m == 2) reach_acc = 1;
            end
            if (reach_acc) begin
                cd.push_back(1'($urandom_range(0, 1)));
                ad.push_back(1'($urandom_range(0, 1)));
                exp_st.push_back(3);
                to  = (t != 0) && (t < d2);
                len = to ? t : d2;
                for (int j = 0; j < len; j++) begin
                    cd.push_back(1'($urandom_range(0, 1)));
                    ad.push_back(j == d2 - 1);
                    exp_st.push_back(j < len - 1 ? 3 : (to ? 5 : 4));
                end
                if (to) code = 3;
            end
        end
        cyc_exp = (m == 3) ? 0 : exp_st.size();
        fin = exp_st[exp_st.size() - 1];
        starts = 0;
        for (int i = 0; i < exp_st.size(); i++) begin
            iGo       = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            iMode     = (i == 0) ? 2'(m) : 2'($urandom);
            iTimeout  = (i == 0) ? 16'(t) : 16'($urandom);
            iCCD_done = cd[i];
            iACC_done = ad[i];
            iAbort    = 1'b0;
            iAck      = 1'b0;
            @(negedge clk);
            n_vec++;
            if (oState !== 3'(exp_st[i])) begin
                n_err++;
                $display("FAIL %s state cycle %0d: got %0d want %0d", name, i, oState, exp_st[i]);
            end
            n_vec++;
            if ({oCCD_en, oACC_en, oACC_start, oBusy} !== flags_of(exp_st[i])) begin
                n_err++;
                $display("FAIL %s enables cycle %0d: got %b want %b", name, i,
                         {oCCD_en, oACC_en, oACC_start, oBusy}, flags_of(exp_st[i]));
            end
            if (oACC_start === 1'b1) starts++;
        end
        n_vec++;
        if (starts !== int'(reach_acc)) begin
            n_err++;
            $display("FAIL %s start pulses: got %0d want %0d", name, starts, int'(reach_acc));
        end
        n_vec++;
        if ({oDone, oError, oErrCode} !== {code == 0, code != 0, 2'(code)}) begin
            n_err++;
            $display("FAIL %s result: got done=%b err=%b code=%0d want code=%0d", name, oDone, oError, oErrCode, code);
        end
        n_vec++;
        if (oCycles !== 16'(cyc_exp)) begin
            n_err++;
            $display("FAIL %s cycles: got %0d want %0d", name, oCycles, cyc_exp);
        end
        held = 16'(cyc_exp);
        for (int i = 0; i < 2; i++) begin
            iGo = 1'b1; iMode = 2'($urandom); iAbort = 1'($urandom_range(0, 1));
            iCCD_done = 1'($urandom_range(0, 1)); iACC_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_vec++;
            if (oState !== 3'(fin) || oCycles !== held) begin
                n_err++;
                $display("FAIL %s terminal hold: got state=%0d cycles=%0d want state=%0d cycles=%0d", name, oState, oCycles, fin, held);
            end
        end
        idle_inputs();
        iAck = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({oState, oDone, oError, oErrCode, oBusy} !== 8'd0 || oCycles !== held) begin
            n_err++;
            $display("FAIL %s ack: got state=%0d done=%b err=%b code=%0d cycles=%0d want idle cycles=%0d",
                     name, oState, oDone, oError, oErrCode, oCycles, held);
        end
        iAck = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({oCCD_en, oACC_en, oACC_start, oBusy, oDone, oError, oErrCode, oState, oCycles} !== 27'd0) begin
            n_err++;
            $display("FAIL reset outputs: got state=%0d code=%0d cycles=%0d want all zero", oState, oErrCode, oCycles);
        end
        rst_n = 1'b1;
        iCCD_done = 1'b1; iACC_done = 1'b1; iAbort = 1'b1;
        @(negedge clk);
        n_vec++;
        if (oState !== 3'd0 || oBusy !== 1'b0) begin
            n_err++;
            $display("FAIL reset idle hold: got state=%0d want 0", oState);
        end
        idle_inputs();
    endtask

    task automatic test_directed_jobs();
        run_job(2, 0, 5, 3, "nominal_cap_acc");
        run_job(0, 4, 40, 1, "ccd_timeout");
        run_job(1, 3, 1, 3, "acc_done_timeout_tie");
        run_job(0, 1, 1, 1, "ccd_tmo1_tie");
        run_job(1, 1, 1, 2, "acc_tmo1");
    endtask

    task automatic test_abort();
        idle_inputs();
        iGo = 1'b1; iMode = 2'b10; iTimeout = 16'd0; iAbort = 1'b1;
        @(negedge clk);
        n_vec++;
        if (oState !== 3'd1) begin
            n_err++;
            $display("FAIL abort_in_idle: got state=%0d want 1", oState);
        end
        iGo = 1'b0; iAbort = 1'b0;
        repeat (2) @(negedge clk);
        iAbort = 1'b1; iCCD_done = 1'b1; iGo = 1'b1; iMode = 2'b00;
        @(negedge clk);
        n_vec++;
        if ({oState, oDone, oError, oCCD_en, oACC_start, oBusy} !== 8'd0 || oCycles !== 16'd4) begin
            n_err++;
            $display("FAIL abort_ccd: got state=%0d done=%b err=%b ccd=%b cycles=%0d want idle cycles=4",
                     oState, oDone, oError, oCCD_en, oCycles);
        end
        idle_inputs();
        @(negedge clk);
        n_vec++;
        if (oState !== 3'd0 || oACC_start !== 1'b0 || oCycles !== 16'd4) begin
            n_err++;
            $display("FAIL abort_go_ignored: got state=%0d start=%b cycles=%0d want 0/0/4", oState, oACC_start, oCycles);
        end
        iGo = 1'b1; iMode = 2'b01; iTimeout = 16'd1;
        @(negedge clk);
        iGo = 1'b0;
        @(negedge clk);
        iAbort = 1'b1; iACC_done = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({oState, oDone, oError, oErrCode, oACC_en} !== 8'd0) begin
            n_err++;
            $display("FAIL abort_acc_wait: got state=%0d done=%b err=%b code=%0d acc=%b want idle",
                     oState, oDone, oError, oErrCode, oACC_en);
        end
        idle_inputs();
        iGo = 1'b1; iMode = 2'b01; iTimeout = 16'd0;
        @(negedge clk);
        iGo = 1'b0; iAbort = 1'b1;
        @(negedge clk);
        n_vec++;
        if (oState !== 3'd0 || oACC_en !== 1'b0 || oACC_start !== 1'b0) begin
            n_err++;
            $display("FAIL abort_acc_start: got state=%0d acc=%b start=%b want idle", oState, oACC_en, oACC_start);
        end
        idle_inputs();
    endtask

    task automatic test_illegal_and_reset();
        run_job(3, 5, 1, 1, "illegal_mode");
        idle_inputs();
        iGo = 1'b1; iMode = 2'b01; iTimeout = 16'd0;
        @(negedge clk);
        iGo = 1'b0;
        @(negedge clk);
        n_vec++;
        if (oState !== 3'd3) begin
            n_err++;
            $display("FAIL pre_reset_state: got %0d want 3", oState);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({oCCD_en, oACC_en, oACC_start, oBusy, oDone, oError, oErrCode, oState, oCycles} !== 27'd0) begin
            n_err++;
            $display("FAIL async_reset: got state=%0d acc=%b busy=%b cycles=%0d want all zero", oState, oACC_en, oBusy, oCycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (oState !== 3'd0 || oACC_start !== 1'b0 || oACC_en !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got state=%0d start=%b want idle", oState, oACC_start);
        end
    endtask

    task automatic test_cycle_saturation();
        idle_inputs();
        iGo = 1'b1; iMode = 2'b00; iTimeout = 16'd0;
        @(negedge clk);
        iGo = 1'b0;
        repeat (65540) @(negedge clk);
        n_vec++;
        if (oState !== 3'd1 || oCycles !== 16'hFFFF) begin
            n_err++;
            $display("FAIL saturate_running: got state=%0d cycles=%0d want 1/65535", oState, oCycles);
        end
        iCCD_done = 1'b1;
        @(negedge clk);
        n_vec++;
        if (oState !== 3'd4 || oDone !== 1'b1 || oCycles !== 16'hFFFF) begin
            n_err++;
            $display("FAIL saturate_done: got state=%0d done=%b cycles=%0d want 4/1/65535", oState, oDone, oCycles);
        end
        idle_inputs();
        iAck = 1'b1;
        @(negedge clk);
        iAck = 1'b0;
    endtask

    task automatic test_random_jobs();
        for (int k = 0; k < 60; k++) begin
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                    int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), "random_job");
        end
    endtask

    initial begin
        test_reset();
        test_directed_jobs();
        test_abort();
        test_illegal_and_reset();
        test_random_jobs();
        test_cycle_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
